// File: rtl/cacheline_adaptor_if.sv
// Cache-side line port and memory-side burst port of the cacheline adaptor.
// slave: the adaptor itself; master: whatever drives the cache and memory sides.
interface cacheline_adaptor_if #(
   parameter int s_line  = 256,
   parameter int s_burst = 64
);
   logic                read_i;
   logic                write_i;
   logic [31:0]         address_i;
   logic [s_line-1:0]   line_i;
   logic [s_line-1:0]   line_o;
   logic                resp_o;
   logic [31:0]         address_o;
   logic                read_o;
   logic                write_o;
   logic [s_burst-1:0]  burst_o;
   logic [s_burst-1:0]  burst_i;
   logic                resp_i;

   modport slave (
      input  read_i, write_i, address_i, line_i, burst_i, resp_i,
      output line_o, resp_o, address_o, read_o, write_o, burst_o
   );

   modport master (
      output read_i, write_i, address_i, line_i, burst_i, resp_i,
      input  line_o, resp_o, address_o, read_o, write_o, burst_o
   );
endinterface

// File: rtl/cacheline_adaptor.sv
// Converts one cache line into a burst of num_beats memory beats and back (fill/writeback).
// 4 beats + 1 response cycle minimum; resp_i low stretches the burst one cycle per wait.
module cacheline_adaptor #(
   parameter int s_line   = 256,
   parameter int s_burst  = 64,
   parameter int s_offset = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   cacheline_adaptor_if.slave   bus
);
   localparam int num_beats = s_line / s_burst;
   localparam int cnt_w     = (num_beats > 1) ? $clog2(num_beats) : 1;

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   state_t              state;
   logic [cnt_w-1:0]    cnt;
   logic [cnt_w-1:0]    cnt_nxt;
   logic [s_line-1:0]   line_buf;
   logic [31:0]         cur_base;
   logic [31:0]         nxt_base;
   logic                last_beat;
   logic [31:0]         aligned;

   assign cnt_nxt   = cnt + 1'b1;
   assign cur_base  = 32'(cnt) * 32'(s_burst);
   assign nxt_base  = 32'(cnt_nxt) * 32'(s_burst);
   assign last_beat = (cnt == cnt_w'(num_beats - 1));
   assign aligned   = {bus.address_i[31:s_offset], {s_offset{1'b0}}};

   assign bus.line_o = line_buf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         line_buf      <= '0;
         bus.resp_o    <= 1'b0;
         bus.read_o    <= 1'b0;
         bus.write_o   <= 1'b0;
         bus.address_o <= '0;
         bus.burst_o   <= '0;
      end else begin
         case (state)
            IDLE: begin
               bus.resp_o <= 1'b0;
               // read takes priority when both requests arrive together
               if (bus.read_i) begin
                  bus.address_o <= aligned;
                  bus.read_o    <= 1'b1;
                  cnt           <= '0;
                  state         <= RD;
               end else if (bus.write_i) begin
                  bus.address_o <= aligned;
                  bus.write_o   <= 1'b1;
                  line_buf      <= bus.line_i;
                  bus.burst_o   <= bus.line_i[s_burst-1:0];
                  cnt           <= '0;
                  state         <= WR;
               end
            end
            RD: begin
               if (bus.resp_i) begin
                  line_buf[cur_base +: s_burst] <= bus.burst_i;
                  cnt <= cnt_nxt;
                  if (last_beat) begin
                     bus.read_o    <= 1'b0;
                     bus.address_o <= '0;
                     bus.resp_o    <= 1'b1;
                     state         <= DONE;
                  end
               end
            end
            WR: begin
               if (bus.resp_i) begin
                  cnt <= cnt_nxt;
                  if (last_beat) begin
                     bus.write_o   <= 1'b0;
                     bus.address_o <= '0;
                     bus.burst_o   <= '0;
                     bus.resp_o    <= 1'b1;
                     state         <= DONE;
                  end else begin
                     // present the next beat so it is ready the cycle after acceptance
                     bus.burst_o <= line_buf[nxt_base +: s_burst];
                  end
               end
            end
            DONE: begin
               bus.resp_o <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: fills, writebacks, wait states, conflicts, reset abort.
module tb_cacheline_adaptor;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   cacheline_adaptor_if #(.s_line(256), .s_burst(64)) bus ();

   cacheline_adaptor #(.s_line(256), .s_burst(64), .s_offset(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge of the cycle after resp_o.
   task automatic run_txn(input bit is_wr, input bit both, input logic [31:0] addr,
                          input logic [255:0] line, input logic [15:0] pat, input int plen,
                          input int exp_lat, input bit poke);
      int b;
      int lat;
      logic [31:0] exp_addr;
      b        = 0;
      lat      = 0;
      exp_addr = {addr[31:5], 5'b0};
      bus.address_i = addr;
      bus.line_i    = line;
      bus.read_i    = !is_wr || both;
      bus.write_i   = is_wr || both;
      @(posedge clk);
      #1;
      bus.read_i    = 1'b0;
      bus.write_i   = 1'b0;
      bus.line_i    = ~line;
      bus.address_i = 32'hffff_ffff;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
         @(negedge clk);
         if (bus.resp_o) begin
            lat = k;
         end else begin
            check("busy_read_o", bus.read_o, !is_wr);
            check("busy_write_o", bus.write_o, is_wr);
            check("busy_address_o", bus.address_o, exp_addr);
            if (is_wr) check("write_beat", bus.burst_o, line[64*b +: 64]);
            bus.resp_i  = (k <= plen) ? pat[k-1] : 1'b1;
            bus.burst_i = bus.resp_i ? line[64*b +: 64] : 64'hdead_beef_0bad_f00d;
            if (bus.resp_i) b++;
            bus.write_i = poke && (k == 2);
         end
      end
      bus.resp_i  = 1'b0;
      bus.write_i = 1'b0;
      check("latency", lat, exp_lat);
      check("done_read_o", bus.read_o, 1'b0);
      check("done_write_o", bus.write_o, 1'b0);
      if (!is_wr) check("fill_line", bus.line_o, line);
      @(negedge clk);
      check("resp_pulse_width", bus.resp_o, 1'b0);
      check("idle_address_o", bus.address_o, 32'h0);
   endtask

   logic [255:0] line_a;
   logic [255:0] line_d;
   logic [255:0] line_w;
   logic [255:0] line_r;

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      bus.read_i = 1'b0;
      bus.write_i = 1'b0;
      bus.address_i = '0;
      bus.line_i = '0;
      bus.burst_i = '0;
      bus.resp_i = 1'b0;
      line_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      line_d = {64'hd3d3_0000_cafe_0003, 64'hd2d2_0000_cafe_0002,
                64'hd1d1_0000_cafe_0001, 64'hd0d0_0000_cafe_0000};
      line_w = {64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210,
                64'haaaa_5555_aaaa_5555, 64'h0f0f_f0f0_0f0f_f0f0};
      line_r = {64'h8888_7777_6666_5555, 64'h1212_3434_5656_7878,
                64'h9999_0000_9999_0000, 64'hbeef_beef_beef_beef};
      #2;
      check("rst_resp_o", bus.resp_o, 1'b0);
      check("rst_read_o", bus.read_o, 1'b0);
      check("rst_write_o", bus.write_o, 1'b0);
      check("rst_address_o", bus.address_o, 32'h0);
      check("rst_burst_o", bus.burst_o, 64'h0);
      check("rst_line_o", bus.line_o, 256'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // plain fill: 0x1234 aligns to 0x1220
      check("align_const", {32'h0000_1234 & 32'hffff_ffe0}, 32'h0000_1220);
      run_txn(1'b0, 1'b0, 32'h0000_1234, line_a, 16'h000f, 4, 5, 1'b0);
      // plain writeback
      run_txn(1'b1, 1'b0, 32'h0000_803f, line_d, 16'h000f, 4, 5, 1'b0);
      // fill with wait pattern 1,0,0,1,1,0,1
      run_txn(1'b0, 1'b0, 32'h1000_0004, line_r, 16'h0059, 7, 8, 1'b0);
      // writeback with waits
      run_txn(1'b1, 1'b0, 32'h2000_0060, line_w, 16'h0035, 6, 7, 1'b0);
      // read and write together, then a write pulse mid-read
      run_txn(1'b0, 1'b1, 32'h0000_abcd, line_w, 16'h000f, 4, 5, 1'b1);

      // reset after two beats of a read
      bus.address_i = 32'h0000_2040;
      bus.read_i = 1'b1;
      @(posedge clk);
      #1;
      bus.read_i = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         bus.resp_i  = 1'b1;
         bus.burst_i = 64'h5555_aaaa_5555_aaaa;
      end
      @(negedge clk);
      bus.resp_i = 1'b0;
      check("pre_abort_read_o", bus.read_o, 1'b1);
      rst_n = 1'b0;
      #1;
      check("abort_read_o", bus.read_o, 1'b0);
      check("abort_resp_o", bus.resp_o, 1'b0);
      check("abort_line_o", bus.line_o, 256'h0);
      check("abort_address_o", bus.address_o, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_txn(1'b0, 1'b0, 32'h0000_2040, line_a, 16'h000f, 4, 5, 1'b0);

      // back-to-back: write then read raised in the bubble cycle after resp_o
      run_txn(1'b1, 1'b0, 32'h0000_4000, line_d, 16'h000f, 4, 5, 1'b0);
      run_txn(1'b0, 1'b0, 32'h0000_4020, line_r, 16'h000f, 4, 5, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
